imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port, variable-latency memory between two requesters: the pipeline fetch stage (PCF/InstrF) and the memory stage (ALUResultM/WriteDataM/MemDataM).
- Arbitrates between them, sequences one outstanding transaction at a time, and returns read data with a one-cycle valid pulse.
- The hazard unit derives StallF/StallM from req & ~gnt and from pending responses.
- Data has priority over fetch, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_kill  in  1  discard any outstanding/returning fetch response (pipeline flush)
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  data request; held with address and data until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (word aligned)
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  byte write enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  raw load word (fed to loaddec)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte mask
- mem_ready  in  1  memory completes the current request this cycle
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, one outstanding transaction.
- IDLE arbitration (combinational grant):
  - d_req wins unless starve_cnt == STARVE_LIMIT and if_req = 1, in which case fetch wins.
  - Exactly one of if_gnt/d_gnt is high; neither is high outside IDLE.
- On grant:
  - The winner's request is latched into mem_* registers and the FSM moves to BUSY_I or BUSY_D.
  - mem_req = 1 from the next cycle.
  - mem_addr/we/wdata/wmask stay stable while mem_req = 1.
  - mem_we = 0 and mem_wmask = 0 for fetch.
- In BUSY_x:
  - mem_req stays high until the cycle with mem_ready = 1.
  - On that edge: mem_req -> 0; rdata captured into if_rdata or d_rdata (stores leave d_rdata unchanged); the matching rvalid is asserted for exactly the next cycle; state -> IDLE.
  - In that next cycle a new grant may occur.
  - Minimum latency: req/gnt at cycle 0, mem_req at cycle 1 (ready = 1), rvalid at cycle 2.
  - Peak throughput: one transaction per 2 cycles.
- mem_ready while in IDLE is ignored.
- Starvation counter starve_cnt (4 bits):
  - On a data grant with if_req = 1: increment, saturating at STARVE_LIMIT.
  - On a fetch grant, or a data grant with if_req = 0: clear.
- if_kill:
  - Any cycle if_kill = 1 during BUSY_I or its mem_ready edge sets a kill flag.
  - The resulting if_rvalid is suppressed and if_rdata is not updated.
  - The flag clears on return to IDLE.
  - if_kill in IDLE withdraws nothing: the requester deasserts if_req itself.
  - Data transactions are unaffected.
- Simultaneous if_kill and if_gnt: the grant stands and the new fetch is not killed.
- Reset (any state, including mid-transaction):
  - Next edge: IDLE; mem_req = mem_we = 0; mem_addr/wdata/wmask = 0.
  - if_gnt = d_gnt = 0 during reset; if_rvalid = d_rvalid = 0; if_rdata = d_rdata = 0.
  - starve_cnt = 0; kill flag = 0.
  - The memory is required to abandon a request when mem_req drops.

Decomposition:
- Shared package arb_pkg:
  - state encoding localparams (S_IDLE = 2'd0, S_BUSY_I = 2'd1, S_BUSY_D = 2'd2)
  - requester IDs (REQ_IF = 1'b0, REQ_D = 1'b1)
  - STARVE_CNT_W = 4
- One sub-module: arb_prio_sel, the combinational winner select from d_req, if_req and starve_cnt, plus the saturating starvation counter register.
- The FSM and response registers stay in the top module.

Test Plan:
- Single fetch, if_addr = 0x0000_0040, memory ready after 3 cycles with 0x0051_0113 -> if_gnt at cycle 0; mem_req on cycles 1-3 with mem_addr = 0x40, mem_we = 0; if_rvalid at cycle 4 with if_rdata = 0x0051_0113.
- if_req and d_req together, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_wmask = 4'hF, zero-wait memory -> d_gnt first; mem_we = 1 with that data; d_rvalid at cycle 2; if_gnt at cycle 2; if_rvalid at cycle 4.
- if_req held and d_req continuously high, STARVE_LIMIT = 4 -> grant order D, D, D, D, I, D...; starve_cnt 1, 2, 3, 4, 0.
- Fetch outstanding, if_kill pulsed at cycle 2, mem_ready at cycle 3 -> no if_rvalid; if_rdata unchanged; a new if_gnt possible at cycle 4.
- Reset asserted while in BUSY_D with mem_req = 1 -> next cycle: mem_req = 0, state IDLE, all outputs 0; the first request after reset is granted normally.
- Load, d_addr = 0x200, memory returns 0x1234_5678 -> d_rvalid pulse with d_rdata = 0x1234_5678; mem_wmask = 0 during the load.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared state encoding, requester IDs and counter width for the
// imem/dmem arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_prio_sel.sv
// Winner select between fetch and data requesters plus the saturating
// fetch-starvation counter that forces a fetch grant after a data streak.
module arb_prio_sel
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic win_valid_o,
  output logic win_id_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] ONE   = {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STARVE_CNT_W-1:0] ZERO  = {STARVE_CNT_W{1'b0}};

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    force_if;

  // Winner select and starvation counter next state.
  always_comb begin
    force_if    = (cnt_q == LIMIT) && if_req_i;
    win_valid_o = 1'b0;
    win_id_o    = REQ_IF;
    cnt_d       = cnt_q;
    if (arb_en_i && d_req_i && !force_if) begin
      win_valid_o = 1'b1;
      win_id_o    = REQ_D;
      if (if_req_i) begin
        if (cnt_q < LIMIT) begin
          cnt_d = cnt_q + ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        cnt_d = ZERO;
      end
    end else if (arb_en_i && if_req_i) begin
      win_valid_o = 1'b1;
      win_id_o    = REQ_IF;
      cnt_d       = ZERO;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch and
// memory pipeline stages, one outstanding transaction at a time.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  input  logic                  if_kill,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wmask,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_e         state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]  mem_wmask_q, mem_wmask_d;
  logic               if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic               d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
  logic               kill_q, kill_d;
  logic               arb_en;
  logic               win_valid;
  logic               win_id;

  // Grants are only offered from IDLE and never while reset is asserted.
  assign arb_en = (state_q == S_IDLE) && !reset;

  arb_prio_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk         (clk),
    .reset       (reset),
    .arb_en_i    (arb_en),
    .if_req_i    (if_req),
    .d_req_i     (d_req),
    .win_valid_o (win_valid),
    .win_id_o    (win_id)
  );

  assign d_gnt  = win_valid && (win_id == REQ_D);
  assign if_gnt = win_valid && (win_id == REQ_IF);

  // FSM next state, memory request latch and response capture.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    kill_d      = kill_q;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (d_gnt) begin
          state_d     = S_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wmask_d = d_wmask;
        end else if (if_gnt) begin
          state_d     = S_BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = {DATA_W{1'b0}};
          mem_wmask_d = {MASK_W{1'b0}};
        end else begin
          mem_req_d = 1'b0;
        end
      end
      S_BUSY_I: begin
        if (mem_ready) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          kill_d    = 1'b0;
          // A kill on the completing edge still discards the response.
          if (!(kill_q || if_kill)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b0;
          end
        end else begin
          kill_d = kill_q || if_kill;
        end
      end
      S_BUSY_D: begin
        if (mem_ready) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        kill_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_wmask_q <= {MASK_W{1'b0}};
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= {DATA_W{1'b0}};
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      kill_q      <= kill_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed scenarios plus a randomized run checked against a
// transaction-level reference model of the arbiter.
module tb_imem_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_kill, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [MW-1:0] d_wmask;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_kill   (if_kill),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = 32'd0; if_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wmask = 4'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"},
              {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, mem_wmask},
              64'd0);
    check_val({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
    check_val({tag, "_maddr"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  // ---------------- reference model state for the random run ----------
  logic [31:0] marr [16];
  bit          m_busy, m_is_d, m_we, m_killed, e_ifv, e_dv;
  logic [31:0] m_addr, m_wdata, e_ifd, e_dd;
  logic [3:0]  m_wmask;
  int          m_streak;

  task automatic random_phase(input int n_cyc);
    bit exp_dg, exp_ig, saw_ig, saw_dg, nxt_ifv, nxt_dv;
    logic [31:0] word;
    for (int i = 0; i < 16; i++) marr[i] = $urandom();
    drive_idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_busy = 1'b0; m_killed = 1'b0; e_ifv = 1'b0; e_dv = 1'b0;
    e_ifd = 32'd0; e_dd = 32'd0; m_streak = 0;
    for (int c = 0; c < n_cyc; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 15)) * 32'd4;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 15)) * 32'd4;
        d_wdata = $urandom();
        d_wmask = 4'($urandom_range(0, 15));
      end
      if_kill   = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = mem_req ? marr[mem_addr[5:2]] : $urandom();
      #2;
      exp_dg = !m_busy && d_req && !(m_streak == LIM && if_req);
      exp_ig = !m_busy && if_req && !exp_dg;
      check_val("r_d_gnt", d_gnt, exp_dg);
      check_val("r_if_gnt", if_gnt, exp_ig);
      check_val("r_if_rvalid", if_rvalid, e_ifv);
      check_val("r_d_rvalid", d_rvalid, e_dv);
      check_val("r_if_rdata", if_rdata, e_ifd);
      check_val("r_d_rdata", d_rdata, e_dd);
      check_val("r_mem_req", mem_req, m_busy);
      if (m_busy) begin
        check_val("r_mem_addr", mem_addr, m_addr);
        check_val("r_mem_we", mem_we, m_we);
        check_val("r_mem_wmask", mem_wmask, m_wmask);
        if (m_we) check_val("r_mem_wdata", mem_wdata, m_wdata);
      end
      // model advance to the next edge
      nxt_ifv = 1'b0;
      nxt_dv  = 1'b0;
      if (m_busy) begin
        if (mem_ready) begin
          word = marr[m_addr[5:2]];
          if (!m_is_d) begin
            if (!(m_killed || if_kill)) begin
              nxt_ifv = 1'b1;
              e_ifd   = word;
            end
          end else begin
            nxt_dv = 1'b1;
            if (!m_we) e_dd = word;
            else begin
              for (int b = 0; b < 4; b++)
                if (m_wmask[b]) marr[m_addr[5:2]][b*8 +: 8] = m_wdata[b*8 +: 8];
            end
          end
          m_busy   = 1'b0;
          m_killed = 1'b0;
        end else if (!m_is_d && if_kill) begin
          m_killed = 1'b1;
        end
      end else if (exp_dg) begin
        m_busy = 1'b1; m_is_d = 1'b1; m_we = d_we; m_addr = d_addr;
        m_wdata = d_wdata; m_wmask = d_wmask;
        m_streak = if_req ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
      end else if (exp_ig) begin
        m_busy = 1'b1; m_is_d = 1'b0; m_we = 1'b0; m_addr = if_addr;
        m_wdata = 32'd0; m_wmask = 4'd0; m_streak = 0;
      end
      e_ifv  = nxt_ifv;
      e_dv   = nxt_dv;
      saw_ig = if_gnt;
      saw_dg = d_gnt;
      tick();
      if (saw_ig) if_req = 1'b0;
      if (saw_dg) d_req = 1'b0;
    end
  endtask

  int exp_ord [6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    int g;
    int budget;
    drive_idle();
    reset = 1'b1;
    tick(); tick();
    // grants are suppressed while reset is high
    if_req = 1'b1; d_req = 1'b1;
    #2;
    check_val("rst_gnt", {if_gnt, d_gnt}, 64'd0);
    drive_idle();
    tick();
    reset = 1'b0;
    #2;
    check_all_zero("rst");

    // single fetch with three wait cycles
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #2;
    check_val("t1_if_gnt", if_gnt, 1'b1);
    check_val("t1_d_gnt", d_gnt, 1'b0);
    tick(); if_req = 1'b0;
    #2;
    check_val("t1_mreq_c1", mem_req, 1'b1);
    check_val("t1_maddr", mem_addr, 32'h40);
    check_val("t1_mwe_mask", {mem_we, mem_wmask}, 5'd0);
    tick(); #2;
    check_val("t1_mreq_c2", mem_req, 1'b1);
    tick(); mem_ready = 1'b1; mem_rdata = 32'h0051_0113;
    #2;
    check_val("t1_mreq_c3", mem_req, 1'b1);
    check_val("t1_rv_c3", if_rvalid, 1'b0);
    tick(); mem_ready = 1'b0;
    #2;
    check_val("t1_rv_c4", if_rvalid, 1'b1);
    check_val("t1_rdata", if_rdata, 32'h0051_0113);
    check_val("t1_mreq_c4", mem_req, 1'b0);
    tick(); #2;
    check_val("t1_rv_c5", if_rvalid, 1'b0);

    // simultaneous fetch and store: data first, zero-wait memory
    if_req = 1'b1; if_addr = 32'h0000_0044;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
    #2;
    check_val("t2_gnt_c0", {if_gnt, d_gnt}, 2'b01);
    tick(); d_req = 1'b0; mem_ready = 1'b1;
    #2;
    check_val("t2_mem_c1", {mem_req, mem_we, mem_wmask}, 6'b11_1111);
    check_val("t2_maddr", mem_addr, 32'h100);
    check_val("t2_mwdata", mem_wdata, 32'hDEAD_BEEF);
    check_val("t2_if_gnt_c1", if_gnt, 1'b0);
    tick(); mem_ready = 1'b0;
    #2;
    check_val("t2_d_rvalid_c2", d_rvalid, 1'b1);
    check_val("t2_d_rdata_store", d_rdata, 32'd0);
    check_val("t2_if_gnt_c2", if_gnt, 1'b1);
    tick(); if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_AAAA;
    #2;
    check_val("t2_maddr_if", mem_addr, 32'h44);
    tick(); mem_ready = 1'b0;
    #2;
    check_val("t2_if_rvalid_c4", if_rvalid, 1'b1);
    check_val("t2_if_rdata", if_rdata, 32'h0000_AAAA);

    // starvation guard: D D D D I D with both requesters always pending
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wmask = 4'd0;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    g = 0;
    budget = 0;
    while (g < 6 && budget < 40) begin
      #2;
      if (if_gnt || d_gnt) begin
        check_val($sformatf("t3_grant%0d", g), d_gnt, exp_ord[g]);
        g++;
      end
      tick();
      budget++;
    end
    if (g < 6) check_val("t3_timeout", g, 6);
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();

    // fetch killed mid-flight, then kill coinciding with a new grant
    if_req = 1'b1; if_addr = 32'h80;
    #2;
    check_val("t4_if_gnt_c0", if_gnt, 1'b1);
    tick(); if_req = 1'b0;
    tick(); if_kill = 1'b1;
    tick(); if_kill = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick(); mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h84; if_kill = 1'b1;
    #2;
    check_val("t4_killed_rv", if_rvalid, 1'b0);
    check_val("t4_rdata_kept", if_rdata, 32'hCAFE_0001);
    check_val("t4_regrant", if_gnt, 1'b1);
    tick(); if_req = 1'b0; if_kill = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_2222;
    #2;
    check_val("t4_maddr", mem_addr, 32'h84);
    tick(); mem_ready = 1'b0;
    #2;
    check_val("t4_new_rv", if_rvalid, 1'b1);
    check_val("t4_new_rdata", if_rdata, 32'h0000_2222);

    // reset during a data transaction, then a normal load
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wmask = 4'd0;
    #2;
    check_val("t5_d_gnt", d_gnt, 1'b1);
    tick(); d_req = 1'b0;
    #2;
    check_val("t5_mreq", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    d_req = 1'b1; d_addr = 32'h200;
    #2;
    check_all_zero("t5_after_rst");
    tick(); reset = 1'b0;
    #2;
    check_val("t5_first_gnt", d_gnt, 1'b1);
    tick(); d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #2;
    check_val("t6_mem", {mem_req, mem_we, mem_wmask}, 6'b10_0000);
    check_val("t6_maddr", mem_addr, 32'h200);
    tick(); mem_ready = 1'b0;
    #2;
    check_val("t6_d_rvalid", d_rvalid, 1'b1);
    check_val("t6_d_rdata", d_rdata, 32'h1234_5678);
    tick(); #2;
    check_val("t6_rv_pulse", d_rvalid, 1'b0);

    random_phase(2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
